// File: rtl/pkt_port_arbiter.sv
// Packet-granular round-robin arbiter: grants one port per packet, forwards its
// beats through a registered mux, and drops/flags beats beyond MAX_PAYLOAD.
module pkt_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_PAYLOAD = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]            bnd_plse_in,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          valid_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          bnd_plse_out,
    output logic                          ovf_err,
    output logic                          busy
);
    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam int LW = $clog2(NUM_REQ);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PAYLOAD);
    localparam logic [LW-1:0] LAST_INIT = LW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} state_t;

    state_t                  state_reg, state_next;
    logic [NUM_REQ-1:0]      gnt_reg, gnt_next;
    logic [LW-1:0]           gidx_reg, gidx_next;
    logic [LW-1:0]           last_reg, last_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    valid_out_reg, valid_out_next;
    logic [DATA_WIDTH-1:0]   data_out_reg, data_out_next;
    logic                    bnd_out_reg, bnd_out_next;
    logic                    ovf_reg, ovf_next;
    logic                    busy_reg, busy_next;

    logic [DATA_WIDTH-1:0]   port_data [NUM_REQ];
    logic                    win_found;
    logic [LW-1:0]           win_idx;
    logic                    beat_valid, beat_bnd, accept, under_max;
    logic [DATA_WIDTH-1:0]   beat_data;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign port_data[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && req[LW'((int'(last_reg) + i) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = LW'((int'(last_reg) + i) % NUM_REQ);
            end
        end
    end

    assign beat_valid = valid_in[gidx_reg];
    assign beat_bnd   = bnd_plse_in[gidx_reg];
    assign beat_data  = port_data[gidx_reg];
    assign accept     = (state_reg == XFER) && beat_valid;
    assign under_max  = (cnt_reg < MAX_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gidx_reg      <= '0;
            last_reg      <= LAST_INIT;
            cnt_reg       <= '0;
            valid_out_reg <= 1'b0;
            data_out_reg  <= '0;
            bnd_out_reg   <= 1'b0;
            ovf_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gidx_reg      <= gidx_next;
            last_reg      <= last_next;
            cnt_reg       <= cnt_next;
            valid_out_reg <= valid_out_next;
            data_out_reg  <= data_out_next;
            bnd_out_reg   <= bnd_out_next;
            ovf_reg       <= ovf_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        gidx_next  = gidx_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    gnt_next   = NUM_REQ'(1) << win_idx;
                    gidx_next  = win_idx;
                    last_next  = win_idx;
                    cnt_next   = '0;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    if (under_max) begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                    // Grant ends on the delimiter or on the first beat past the limit.
                    if (beat_bnd || !under_max) begin
                        gnt_next   = '0;
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        valid_out_next = accept && under_max;
        data_out_next  = (accept && under_max) ? beat_data : '0;
        bnd_out_next   = accept && under_max && beat_bnd;
        ovf_next       = accept && !under_max && !beat_bnd;
        busy_next      = (state_next != IDLE);
    end

    assign gnt          = gnt_reg;
    assign valid_out    = valid_out_reg;
    assign data_out     = data_out_reg;
    assign bnd_plse_out = bnd_out_reg;
    assign ovf_err      = ovf_reg;
    assign busy         = busy_reg;
endmodule

// File: doc/pkt_port_arbiter.md
# pkt_port_arbiter

Round-robin arbiter and sequencer that shares one packet output channel of the DUT among `NUM_REQ` requesting input ports. It grants the channel for one whole packet at a time, using the boundary pulse (`bnd_plse`) as the packet delimiter. It forwards the granted port's beats through a registered mux, enforces a maximum payload length and flags overflow. It sits between the per-port input buffers and the shared output stage inside `dut_top`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesting ports (2..8)
- `DATA_WIDTH`, 8, width of one payload beat
- `MAX_PAYLOAD`, 16, maximum beats per packet, including the beat carrying `bnd_plse`

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  `NUM_REQ`  per-port request; the port holds it high until its grant ends
- `valid_in`  in  `NUM_REQ`  per-port beat valid
- `data_in`  in  `NUM_REQ*DATA_WIDTH`  per-port beat data; port n occupies `[n*DATA_WIDTH +: DATA_WIDTH]`
- `bnd_plse_in`  in  `NUM_REQ`  per-port last-beat pulse; sampled only together with `valid_in`
- `gnt`  out  `NUM_REQ`  one-hot grant, registered
- `valid_out`  out  1  forwarded beat valid
- `data_out`  out  `DATA_WIDTH`  forwarded beat data
- `bnd_plse_out`  out  1  forwarded last-beat pulse
- `ovf_err`  out  1  one-cycle pulse when a packet exceeds `MAX_PAYLOAD`
- `busy`  out  1  high while the FSM is not in IDLE

## Operation
The FSM has three states: IDLE, XFER and GAP.

- **IDLE.** If `req` is non-zero, pick a winner by round-robin. The search starts at `last+1` and wraps modulo `NUM_REQ`. Set `gnt` one-hot to the winner, set `last` to the winner, clear `cnt`, and go to XFER. If `req` is zero, stay in IDLE.
- **XFER.** Only beats from the granted port `g` are used; other ports' `valid_in`, `data_in` and `bnd_plse_in` are ignored. On each cycle with `valid_in[g]` high:
  - Increment `cnt`.
  - If `cnt` was below `MAX_PAYLOAD`, forward the beat: `valid_out`=1, `data_out`=the beat, `bnd_plse_out`=`bnd_plse_in[g]`.
  - If `bnd_plse_in[g]`=1, clear `gnt` and go to GAP.
  - If `cnt`==`MAX_PAYLOAD` and the beat arrives without `bnd_plse_in[g]`, it is the (MAX+1)th beat. Do not forward it. Pulse `ovf_err`, clear `gnt` and go to GAP. The rest of that packet is discarded by the port.
  - Cycles with `valid_in[g]` low leave `cnt` and state unchanged; there is no timeout.
- **GAP.** One idle cycle with all outputs low except `busy`. Then return to IDLE.

Deasserting `req[g]` during XFER has no effect; only `bnd_plse` or overflow ends a grant.

Width rules:
- `cnt` is `$clog2(MAX_PAYLOAD+1)` bits wide and saturates at `MAX_PAYLOAD`.
- `last` is `$clog2(NUM_REQ)` bits wide and wraps around.

Reset (`reset`=0, at any time including mid-packet):
- State returns to IDLE; `gnt`, `valid_out`, `data_out`, `bnd_plse_out`, `ovf_err`, `busy` and `cnt` clear to 0.
- `last` is set to `NUM_REQ-1`, so port 0 has highest priority after reset.
- The in-flight packet is dropped and no `bnd_plse_out` is emitted for it.

## Timing
- From `req` sampled high in IDLE, `gnt` rises on the next edge: 1-cycle arbitration latency.
- Data latency is 1 cycle. A beat accepted at edge k appears on `valid_out`, `data_out` and `bnd_plse_out` after edge k, for exactly one cycle.
- `gnt` falls at the edge where the `bnd_plse` beat or the overflow beat is sampled.
- The minimum re-grant spacing is one GAP cycle plus one IDLE cycle. Back-to-back packets therefore have 2 dead cycles between the last beat of one and the first grant-cycle beat of the next.
- Simultaneous requests are resolved by the round-robin order described above.
- A new `req` that rises in the same cycle as the current packet's `bnd_plse` is not lost; it is arbitrated in the following IDLE.
- A 1-beat packet (`bnd_plse` on the first beat) is legal: `cnt`=1.
- All outputs are driven from registers; there is no combinational path from inputs to outputs.

## Test plan
- **Single port, min payload.** `req[2]`=1, then one beat 0xA5 with `bnd_plse`. Required: `gnt`=4'b0100 for 1 cycle; `data_out`=0xA5 with `bnd_plse_out`=1 one cycle later; `ovf_err`=0.
- **Max payload.** Port 0 sends 16 beats 0x00..0x0F, with `bnd_plse` on 0x0F. Required: all 16 beats forwarded in order; `bnd_plse_out` only on 0x0F; `ovf_err` never asserted.
- **Overflow.** Port 1 sends 17 beats without `bnd_plse`. Required: 16 beats forwarded; `ovf_err` pulses one cycle, aligned to where the 17th beat would appear; `gnt` drops; `bnd_plse_out` never asserted.
- **Round-robin fairness.** All four `req` bits held high out of reset, each port sending 2-beat packets. Required grant order 0,1,2,3,0, with 2 dead cycles between packets.
- **BND_PLSE coincidence.** Port 0's `bnd_plse` beat coincides with `req[3]` rising. Required: next grant goes to port 3 after GAP and IDLE; port 0's last beat is forwarded intact.
- **Reset mid-packet.** `reset` is pulled low for 1 ns after the 3rd beat of a 10-beat packet on port 2. Required: all outputs 0 immediately. After release, with `req[2]` still high and `req[0]` high, the grant goes to port 0 first.
